// File: rtl/clk_gate_ctrl.sv
// Shared gated-clock domain controller: arbitrates NUM_REQ level requesters,
// sequences clk_en_o through OFF/WAKE/ON/IDLE with idle hysteresis, and counts enabled cycles.
module clk_gate_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    input  logic               force_on_i,
    input  logic [CNT_W-1:0]   hyst_cfg_i,
    output logic               clk_en_o,
    output logic [1:0]         state_o,
    output logic [31:0]        on_cycles_o
);
    localparam int WW = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      wake_q, wake_d;
    logic [CNT_W-1:0]   hyst_q, hyst_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               clk_en_q, clk_en_d;
    logic [31:0]        on_cycles_q, on_cycles_d;
    logic               any_act;

    assign any_act = (|req_i) | force_on_i;

    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        hyst_d  = hyst_q;
        case (state_q)
            S_OFF: begin
                if (any_act) begin
                    state_d = S_WAKE;
                    wake_d  = WW'(WAKE_LAT - 1);
                end
            end
            S_WAKE: begin
                // Wake always runs to completion, even if every request has gone.
                if (wake_q == '0) state_d = S_ON;
                else              wake_d  = wake_q - 1'b1;
            end
            S_ON: begin
                if (!any_act) begin
                    state_d = S_IDLE;
                    hyst_d  = hyst_cfg_i;
                end
            end
            S_IDLE: begin
                if (any_act)              state_d = S_ON;
                else if (hyst_q == '0)    state_d = S_OFF;
                else                      hyst_d  = hyst_q - 1'b1;
            end
            default: state_d = S_OFF;
        endcase

        // Enable derives from the next state, so it only moves on OFF<->non-OFF edges.
        clk_en_d    = (state_d != S_OFF);
        ack_d       = (state_d == S_ON) ? req_i : '0;
        on_cycles_d = (clk_en_q && !(&on_cycles_q)) ? on_cycles_q + 32'd1 : on_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            wake_q      <= '0;
            hyst_q      <= '0;
            ack_q       <= '0;
            clk_en_q    <= 1'b0;
            on_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            wake_q      <= wake_d;
            hyst_q      <= hyst_d;
            ack_q       <= ack_d;
            clk_en_q    <= clk_en_d;
            on_cycles_q <= on_cycles_d;
        end
    end

    assign ack_o       = ack_q;
    assign clk_en_o    = clk_en_q;
    assign state_o     = state_q;
    assign on_cycles_o = on_cycles_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized traffic,
// all compared each cycle against a cycle-level behavioural model.
module tb_clk_gate_ctrl;
    localparam int NR = 4;
    localparam int WL = 2;
    localparam int CW = 8;
    localparam int P_OFF = 0, P_WAKE = 1, P_ON = 2, P_IDLE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_i = '0;
    logic [NR-1:0] ack_o;
    logic          force_on_i = 1'b0;
    logic [CW-1:0] hyst_cfg_i = '0;
    logic          clk_en_o;
    logic [1:0]    state_o;
    logic [31:0]   on_cycles_o;

    clk_gate_ctrl #(.NUM_REQ(NR), .WAKE_LAT(WL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .ack_o(ack_o), .force_on_i(force_on_i),
        .hyst_cfg_i(hyst_cfg_i), .clk_en_o(clk_en_o), .state_o(state_o),
        .on_cycles_o(on_cycles_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model: phase plus two "cycles left" timers.
    int          m_ph = P_OFF;
    int          m_wake_left = 0;
    int          m_idle_left = 0;
    logic        m_en = 1'b0;
    logic [NR-1:0] m_ack = '0;
    longint      m_cnt = 0;

    task automatic model_edge();
        bit act;
        if (rst) begin
            m_ph = P_OFF; m_wake_left = 0; m_idle_left = 0;
            m_en = 1'b0; m_ack = '0; m_cnt = 0;
            return;
        end
        if (m_en) m_cnt = (m_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        act = (req_i != 0) || force_on_i;
        if (m_ph == P_OFF) begin
            if (act) begin m_ph = P_WAKE; m_wake_left = WL; end
        end else if (m_ph == P_WAKE) begin
            m_wake_left--;
            if (m_wake_left == 0) m_ph = P_ON;
        end else if (m_ph == P_ON) begin
            if (!act) begin m_ph = P_IDLE; m_idle_left = int'(hyst_cfg_i) + 1; end
        end else begin
            if (act) m_ph = P_ON;
            else begin
                m_idle_left--;
                if (m_idle_left == 0) m_ph = P_OFF;
            end
        end
        m_en  = (m_ph != P_OFF);
        m_ack = (m_ph == P_ON) ? req_i : '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state_o), 32'(m_ph));
        chk("clk_en", 32'(clk_en_o), 32'(m_en));
        chk("ack", 32'(ack_o), 32'(m_ack));
        chk("on_cycles", on_cycles_o, m_cnt[31:0]);
        if (ack_o != 0) chk("en_while_ack", 32'(clk_en_o), 32'd1);
    endtask

    task automatic wait_state(input int s);
        int n = 0;
        while (32'(state_o) != s && n < 20) begin step(); n++; end
        chk("wait_state_timeout", 32'(state_o), 32'(s));
    endtask

    task automatic count_idle(input int want);
        int n = 0;
        while (32'(state_o) == P_IDLE && n < 300) begin
            chk("idle_en", 32'(clk_en_o), 32'd1);
            step(); n++;
        end
        chk("idle_cycles", 32'(n), 32'(want));
        chk("off_after_idle", 32'(state_o), P_OFF);
        chk("off_en", 32'(clk_en_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        chk("rst_state", 32'(state_o), P_OFF);
        chk("rst_cnt", on_cycles_o, 32'd0);
        rst = 1'b0;
        step();

        // Wake latency from OFF
        req_i = 4'b0001; hyst_cfg_i = 8'd5;
        step();
        chk("c1_en", 32'(clk_en_o), 32'd1);
        chk("c1_state", 32'(state_o), P_WAKE);
        step();
        chk("c2_state", 32'(state_o), P_WAKE);
        chk("c2_ack", 32'(ack_o), 32'd0);
        step();
        chk("c3_state", 32'(state_o), P_ON);
        chk("c3_ack", 32'(ack_o), 32'b0001);

        // Second requester joins, then both drop
        req_i = 4'b0101; step();
        chk("ack_0101", 32'(ack_o), 32'b0101);
        req_i = 4'b0000; step();
        chk("drop_ack", 32'(ack_o), 32'd0);
        chk("drop_idle", 32'(state_o), P_IDLE);
        count_idle(6);

        // Zero hysteresis
        hyst_cfg_i = 8'd0; req_i = 4'b0010;
        step(); wait_state(P_ON);
        req_i = '0; step();
        count_idle(1);

        // Request arrives in the last IDLE cycle
        hyst_cfg_i = 8'd2; req_i = 4'b1000;
        step(); wait_state(P_ON);
        req_i = '0; step();
        hyst_cfg_i = 8'd0;
        step(); step();
        chk("last_idle", 32'(state_o), P_IDLE);
        req_i = 4'b1000; step();
        chk("win_state", 32'(state_o), P_ON);
        chk("win_ack", 32'(ack_o), 32'b1000);
        chk("win_en", 32'(clk_en_o), 32'd1);

        // Force keeps clock on without acks
        force_on_i = 1'b1; req_i = '0;
        for (int i = 0; i < 20; i++) step();
        chk("force_state", 32'(state_o), P_ON);
        chk("force_ack", 32'(ack_o), 32'd0);
        hyst_cfg_i = 8'd3; force_on_i = 1'b0; step();
        hyst_cfg_i = 8'd0;
        count_idle(4);

        // Reset mid-operation with acks high
        req_i = 4'b0110; step(); wait_state(P_ON); step();
        chk("pre_rst_ack", 32'(ack_o), 32'b0110);
        rst = 1'b1; step();
        chk("mid_rst_state", 32'(state_o), P_OFF);
        chk("mid_rst_en", 32'(clk_en_o), 32'd0);
        chk("mid_rst_ack", 32'(ack_o), 32'd0);
        chk("mid_rst_cnt", on_cycles_o, 32'd0);
        rst = 1'b0; req_i = '0; step();

        // Saturation of the enabled-cycle counter
        force_on_i = 1'b1; step(); wait_state(P_ON);
        force dut.on_cycles_q = 32'hFFFF_FFFD;
        m_cnt = 64'hFFFF_FFFD;
        #1 release dut.on_cycles_q;
        for (int i = 0; i < 5; i++) step();
        chk("sat", on_cycles_o, 32'hFFFF_FFFF);
        force_on_i = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req_i = NR'($urandom) & NR'($urandom);
            if ($urandom_range(0, 40) == 0) force_on_i = ~force_on_i;
            hyst_cfg_i = CW'($urandom_range(0, 6));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
